// File: rtl/trap_sequencer_pkg.sv
// Shared types for the trap sequencer.
// Holds the FSM state and request-kind enums, the xtvec register layout,
// tvec mode and privilege encodings, and a helper that strips the mode bits
// from an xtvec value to get its aligned base address.
package trap_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_DRAIN,
    S_COMMIT,
    S_REDIRECT
  } trap_seq_state_t;

  typedef enum logic {
    KIND_TRAP,
    KIND_RET
  } trap_seq_kind_t;

  // xtvec layout: word-aligned base in [31:2], mode in [1:0].
  typedef struct packed {
    logic [29:0] base;
    logic [1:0]  mode;
  } csr_xtvec_t;

  localparam logic [1:0] TVEC_MODE_DIRECT   = 2'd0;
  localparam logic [1:0] TVEC_MODE_VECTORED = 2'd1;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  function automatic logic [31:0] tvec_base(input csr_xtvec_t tv);
    return {tv.base, 2'b00};
  endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// Bundle of every signal between the trap sequencer and its neighbours
// (RegWriteStage requests, CSR tvec/epc values and commit pulses,
// PipelineController flush/busy, FetchUnit drain status and redirect).
//   master : the trap sequencer side
//   slave  : the surrounding pipeline / CSR / fetch side
// Redirect handshake: redirectPc is meaningful while redirectValid is high
// and must not change until a cycle in which redirectValid && redirectReady
// are both high; that cycle transfers the PC and redirectValid drops on the
// following cycle.
interface trap_sequencer_if;
  import trap_sequencer_pkg::*;

  logic        trapReq;
  logic        trapIsInterrupt;
  logic [4:0]  trapCause;
  logic        returnReq;
  logic [1:0]  returnPriv;
  logic [1:0]  nextPriv;
  csr_xtvec_t  mtvec;
  csr_xtvec_t  stvec;
  csr_xtvec_t  utvec;
  logic [31:0] mepc;
  logic [31:0] sepc;
  logic [31:0] uepc;
  logic        lsuBusy;
  logic        fetchBusy;
  logic        redirectReady;

  logic        busy;
  logic        flush;
  logic        trapCommit;
  logic        returnCommit;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        drainTimeout;

  modport master (
    input  trapReq, trapIsInterrupt, trapCause, returnReq, returnPriv, nextPriv,
    input  mtvec, stvec, utvec, mepc, sepc, uepc,
    input  lsuBusy, fetchBusy, redirectReady,
    output busy, flush, trapCommit, returnCommit, redirectValid, redirectPc,
    output drainTimeout
  );

  modport slave (
    output trapReq, trapIsInterrupt, trapCause, returnReq, returnPriv, nextPriv,
    output mtvec, stvec, utvec, mepc, sepc, uepc,
    output lsuBusy, fetchBusy, redirectReady,
    input  busy, flush, trapCommit, returnCommit, redirectValid, redirectPc,
    input  drainTimeout
  );

endinterface

// File: rtl/trap_target_calc.sv
// Combinational redirect-target computation.
// Ports:
//   i_kind        trap or xRET
//   i_priv        latched privilege (U=0, S=1, M=3; 2 is treated as M)
//   i_cause       latched trap cause
//   i_is_int      latched interrupt flag
//   i_mtvec/i_stvec/i_utvec, i_mepc/i_sepc/i_uepc  CSR values
//   o_target_pc   xepc for xRET, tvec base (+ cause*4 if vectored interrupt)
module trap_target_calc
  import trap_sequencer_pkg::*;
(
  input  trap_seq_kind_t i_kind,
  input  logic [1:0]     i_priv,
  input  logic [4:0]     i_cause,
  input  logic           i_is_int,
  input  csr_xtvec_t     i_mtvec,
  input  csr_xtvec_t     i_stvec,
  input  csr_xtvec_t     i_utvec,
  input  logic [31:0]    i_mepc,
  input  logic [31:0]    i_sepc,
  input  logic [31:0]    i_uepc,
  output logic [31:0]    o_target_pc
);

  csr_xtvec_t  w_tvec;
  logic [31:0] w_epc;
  logic [31:0] w_base;
  logic [31:0] w_offset;

  always_comb begin
    // Default covers M and the reserved encoding 2.
    w_tvec = i_mtvec;
    w_epc  = i_mepc;
    case (i_priv)
      PRIV_U: begin
        w_tvec = i_utvec;
        w_epc  = i_uepc;
      end
      PRIV_S: begin
        w_tvec = i_stvec;
        w_epc  = i_sepc;
      end
      default: begin
        w_tvec = i_mtvec;
        w_epc  = i_mepc;
      end
    endcase
  end

  assign w_base   = tvec_base(w_tvec);
  assign w_offset = {25'd0, i_cause, 2'b00};

  always_comb begin
    o_target_pc = w_base;
    if (i_kind == KIND_RET) begin
      o_target_pc = w_epc;
    end else if (w_tvec.mode == TVEC_MODE_VECTORED && i_is_int) begin
      // Modes 2/3 fall through to direct; the add wraps at 32 bits.
      o_target_pc = w_base + w_offset;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry / xRET sequencer.
// Takes a single-cycle trap or return request, pulses a pipeline flush,
// waits for fetch and LSU to go idle (bounded by DRAIN_TIMEOUT), pulses the
// matching CSR commit, then offers the redirect PC to fetch until accepted.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   bus_if         request, CSR, drain-status and redirect signals
//   o_dbg_state    current FSM state
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int DRAIN_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  trap_sequencer_if.master bus_if,
  output trap_seq_state_t  o_dbg_state
);

  localparam int               CNT_W    = $clog2(DRAIN_TIMEOUT + 1);
  // The drain cycle in which the counter holds this value is the last one.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  trap_seq_state_t r_state;
  trap_seq_state_t w_state_next;
  trap_seq_kind_t  r_kind;
  logic [1:0]      r_priv;
  logic [4:0]      r_cause;
  logic            r_is_int;
  logic [CNT_W-1:0] r_drain_cnt;
  logic            r_drain_timeout;
  logic [31:0]     r_redirect_pc;
  logic            w_timeout_hit;
  logic [31:0]     w_target_pc;

  trap_target_calc u_target (
    .i_kind      (r_kind),
    .i_priv      (r_priv),
    .i_cause     (r_cause),
    .i_is_int    (r_is_int),
    .i_mtvec     (bus_if.mtvec),
    .i_stvec     (bus_if.stvec),
    .i_utvec     (bus_if.utvec),
    .i_mepc      (bus_if.mepc),
    .i_sepc      (bus_if.sepc),
    .i_uepc      (bus_if.uepc),
    .o_target_pc (w_target_pc)
  );

  always_comb begin
    w_state_next  = r_state;
    w_timeout_hit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus_if.trapReq || bus_if.returnReq) w_state_next = S_FLUSH;
      end
      S_FLUSH: w_state_next = S_DRAIN;
      S_DRAIN: begin
        // A clean drain takes priority over a timeout landing the same cycle.
        if (!bus_if.lsuBusy && !bus_if.fetchBusy) begin
          w_state_next = S_COMMIT;
        end else if (r_drain_cnt >= CNT_LAST) begin
          w_state_next  = S_COMMIT;
          w_timeout_hit = 1'b1;
        end
      end
      S_COMMIT: w_state_next = S_REDIRECT;
      S_REDIRECT: begin
        if (bus_if.redirectReady) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_kind          <= KIND_TRAP;
      r_priv          <= 2'd0;
      r_cause         <= 5'd0;
      r_is_int        <= 1'b0;
      r_drain_cnt     <= '0;
      r_drain_timeout <= 1'b0;
      r_redirect_pc   <= 32'd0;
    end else begin
      r_state <= w_state_next;

      // Requests are only looked at in IDLE; trap wins a same-cycle tie.
      if (r_state == S_IDLE) begin
        if (bus_if.trapReq) begin
          r_kind   <= KIND_TRAP;
          r_priv   <= bus_if.nextPriv;
          r_cause  <= bus_if.trapCause;
          r_is_int <= bus_if.trapIsInterrupt;
        end else if (bus_if.returnReq) begin
          r_kind <= KIND_RET;
          r_priv <= bus_if.returnPriv;
        end
      end

      if (r_state == S_FLUSH) begin
        r_drain_cnt <= '0;
      end else if (r_state == S_DRAIN && r_drain_cnt != CNT_MAX) begin
        r_drain_cnt <= r_drain_cnt + 1'b1;
      end

      if (w_timeout_hit) r_drain_timeout <= 1'b1;

      // Capture the target as REDIRECT is entered so it stays stable while
      // fetch holds off the handshake.
      if (r_state == S_COMMIT) r_redirect_pc <= w_target_pc;
    end
  end

  assign bus_if.busy          = (r_state != S_IDLE);
  assign bus_if.flush         = (r_state == S_FLUSH);
  assign bus_if.trapCommit    = (r_state == S_COMMIT) && (r_kind == KIND_TRAP);
  assign bus_if.returnCommit  = (r_state == S_COMMIT) && (r_kind == KIND_RET);
  assign bus_if.redirectValid = (r_state == S_REDIRECT);
  assign bus_if.redirectPc    = r_redirect_pc;
  assign bus_if.drainTimeout  = r_drain_timeout;
  assign o_dbg_state          = r_state;

endmodule
